// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I cores: opcode values, the multicycle
// controller state encoding, and the encodings of the ALU-op, immediate-type
// and datapath mux selects driven by the controllers.
// -----------------------------------------------------------------------------
package riscv_pkg;

   // Supported opcodes (instr[6:0])
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   // Multicycle controller states
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   // alu_op encodings consumed by the ALU decoder
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // Immediate formats
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result mux select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // True for the two opcodes that access data memory
   function automatic logic op_is_mem(input logic [6:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage : riscv_pkg

// File: rtl/imm_src_decoder.sv
// -----------------------------------------------------------------------------
// imm_src_decoder
// Maps an opcode to the immediate format used by the immediate extender.
// Purely combinational so it can be shared by single- and multicycle cores.
// Ports:
//   op      in  7  instr[6:0]
//   imm_src out 2  00=I 01=S 10=B 11=J
// -----------------------------------------------------------------------------
module imm_src_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] imm_src
);

   // Opcode to immediate format; R-type and unknown opcodes fall back to I
   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_LW, OP_ITYPE: imm_src = IMM_I;
         OP_SW:           imm_src = IMM_S;
         OP_BEQ:          imm_src = IMM_B;
         OP_JAL:          imm_src = IMM_J;
         default:         imm_src = IMM_I;
      endcase
   end

endmodule : imm_src_decoder

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq,
// jal). Sequences the shared ALU, the unified memory port and the register
// file. Outputs are decoded from the state register; only the strobes that
// depend on mem_ready or zero are qualified combinationally.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op                  instr[6:0] from IR (sampled in DECODE and MEMADR)
//   zero                ALU zero flag (used in BEQ)
//   mem_ready           memory completes current access this cycle
//   mem_req, adr_src    memory request and address select (0=PC, 1=Result)
//   mem_write, ir_write, pc_write, reg_write   write strobes
//   alu_src_a/b, result_src, alu_op, imm_src   datapath selects
//   illegal_op          sticky flag, set on an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_controller
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] alu_op,
   output logic [1:0] imm_src,
   output logic       illegal_op
);

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;

   logic   mem_write_s, ir_write_s, pc_write_s, reg_write_s;

   imm_src_decoder u_imm_src_decoder (
      .op      (op),
      .imm_src (imm_src)
   );

   // State and sticky illegal-opcode flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic; op is only looked at in DECODE and MEMADR
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
            else           state_d = S_FETCH;
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_ITYPE:     state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) state_d = S_MEMREAD;
            else             state_d = S_MEMWRITE;
         end
         S_MEMREAD: begin
            if (mem_ready) state_d = S_MEMWB;
            else           state_d = S_MEMREAD;
         end
         S_MEMWB: state_d = S_FETCH;
         S_MEMWRITE: begin
            if (mem_ready) state_d = S_FETCH;
            else           state_d = S_MEMWRITE;
         end
         S_EXECR: state_d = S_ALUWB;
         S_EXECI: state_d = S_ALUWB;
         S_ALUWB: state_d = S_FETCH;
         S_BEQ:   state_d = S_FETCH;
         S_JAL:   state_d = S_ALUWB;   // write PC+4 (held in ALUOut) to rd
         S_TRAP:  state_d = S_TRAP;    // only reset leaves TRAP
         default: state_d = S_FETCH;
      endcase
   end

   // Sticky flag rises together with entry into TRAP
   always_comb begin
      if (state_d == S_TRAP) illegal_d = 1'b1;
      else                   illegal_d = illegal_q;
   end

   // State-decoded selects and enables; unlisted selects stay 0
   always_comb begin
      mem_req     = 1'b0;
      adr_src     = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      pc_write_s  = 1'b0;
      reg_write_s = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      result_src  = RES_ALUOUT;
      alu_op      = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write_s = mem_ready;
            pc_write_s = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;    // branch target into ALUOut
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src  = RES_DATA;
            reg_write_s = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req     = 1'b1;
            adr_src     = 1'b1;
            mem_write_s = mem_ready;   // one strobe, on the completing cycle
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALU_SUB;
            pc_write_s = zero;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write_s = 1'b1;
         end
         S_TRAP: begin
            mem_req = 1'b0;
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
   end

   // FETCH is entered asynchronously by reset, but its mem_ready-driven strobes
   // must not fire while reset is held, so every write strobe is gated here.
   assign mem_write  = mem_write_s & rst_n;
   assign ir_write   = ir_write_s  & rst_n;
   assign pc_write   = pc_write_s  & rst_n;
   assign reg_write  = reg_write_s & rst_n;
   assign illegal_op = illegal_q;

endmodule : multicycle_controller
